// File: rtl/ivl_uvm_parity_pkg.sv
// rtl/ivl_uvm_parity_pkg.sv - shared types and parity helper for the odd-parity transmitter
package ivl_uvm_parity_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    localparam int PAR_MAX_W = 64;

    // Callers zero-extend narrower words; extra zeros leave the reduction unchanged.
    function automatic logic odd_par(input logic [PAR_MAX_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ivl_uvm_parity_skid_buf.sv
// rtl/ivl_uvm_parity_skid_buf.sv - 2-entry valid/ready skid buffer over {parity,data}
module ivl_uvm_parity_skid_buf
    import ivl_uvm_parity_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push, pop;

    assign in_ready  = !reset && (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    head_d  = in_data;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    tail_d  = in_data;
                    state_d = BUF_FULL;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                // No push is possible here because in_ready is low.
                if (pop) begin
                    head_d  = tail_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
            head_q  <= {1'b1, {(W-1){1'b0}}};
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/ivl_uvm_odd_parity_tx.sv
// rtl/ivl_uvm_odd_parity_tx.sv - odd-parity word transmitter; IVL_UVM_ODD_PARITY_INJ_EN enables fault injection
module ivl_uvm_odd_parity_tx
    import ivl_uvm_parity_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int INJ_PERIOD = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             inj_enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] inj_cnt
);

    logic             accept;
    logic             flip;
    logic [WIDTH:0]   coded;
    logic [WIDTH:0]   head;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    assign accept = in_valid && in_ready;

`ifdef IVL_UVM_ODD_PARITY_INJ_EN
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;

    always_comb begin
        per_d     = per_q;
        inj_cnt_d = inj_cnt_q;
        flip      = 1'b0;
        if (accept && inj_enable) begin
            if (per_q == CNT_W'(INJ_PERIOD - 1)) begin
                flip      = 1'b1;
                per_d     = '0;
                inj_cnt_d = inj_cnt_q + CNT_W'(1);
            end else begin
                per_d = per_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            per_q     <= '0;
            inj_cnt_q <= '0;
        end else begin
            per_q     <= per_d;
            inj_cnt_q <= inj_cnt_d;
        end
    end

    assign inj_cnt = inj_cnt_q;
`else
    logic unused_inj_enable;
    assign unused_inj_enable = inj_enable;
    assign flip              = 1'b0;
    assign inj_cnt           = '0;
`endif

    // Parity is fixed at acceptance and travels with the word through the buffer.
    assign coded = {odd_par(PAR_MAX_W'(in_data)) ^ flip, in_data};

    ivl_uvm_parity_skid_buf #(.W(WIDTH + 1)) u_buf (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (coded),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_parity = head[WIDTH];
    assign out_data   = head[WIDTH-1:0];

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (out_valid && out_ready) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_ivl_uvm_odd_parity_tx.sv
// tb/tb_ivl_uvm_odd_parity_tx.sv - randomized self-checking bench with queue-based reference model
module tb_ivl_uvm_odd_parity_tx;

    localparam int WIDTH = 4;
    localparam int INJ_P = 4;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             inj_enable = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] inj_cnt;

    int checks = 0;
    int errors = 0;
    int ovl_fires = 0;

    logic [WIDTH:0] mq[$];
    int             m_wc = 0;
    int             m_ic = 0;
    int             m_per = 0;

    always #5 clock = ~clock;

    ivl_uvm_odd_parity_tx #(.WIDTH(WIDTH), .INJ_PERIOD(INJ_P), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .inj_enable (inj_enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity),
        .word_cnt   (word_cnt),
        .inj_cnt    (inj_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: odd parity means an even count of ones in the data gets parity 1.
    function automatic logic model_par(input logic [WIDTH-1:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    always @(negedge clock) begin
        logic           m_in_ready;
        logic           push, pop;
        logic [WIDTH:0] w;
        m_in_ready = !reset && (mq.size() < 2);
        chk("in_ready", 32'(in_ready), 32'(m_in_ready));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0)
            chk("out_word", 32'({out_parity, out_data}), 32'(mq[0]));
        chk("word_cnt", 32'(word_cnt), 32'(m_wc % (1 << CNT_W)));
        chk("inj_cnt", 32'(inj_cnt), 32'(m_ic % (1 << CNT_W)));
        if (out_valid && out_ready && ((^{out_parity, out_data}) == 1'b0))
            ovl_fires++;

        if (reset) begin
            mq.delete();
            m_wc  = 0;
            m_ic  = 0;
            m_per = 0;
        end else begin
            push = in_valid && m_in_ready;
            pop  = (mq.size() != 0) && out_ready;
            if (pop) begin
                void'(mq.pop_front());
                m_wc++;
            end
            if (push) begin
                w = {model_par(in_data), in_data};
`ifdef IVL_UVM_ODD_PARITY_INJ_EN
                if (inj_enable) begin
                    m_per++;
                    if (m_per == INJ_P) begin
                        w[WIDTH] = ~w[WIDTH];
                        m_per    = 0;
                        m_ic++;
                    end
                end
`endif
                mq.push_back(w);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [15:0] par_lit;
        int          exp_inj;
        par_lit = 16'b1001_0110_0110_1001;

        // Reset with in_valid high.
        reset = 1'b1; in_valid = 1'b1; in_data = 4'hA;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_parity", 32'(out_parity), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_inj_cnt", 32'(inj_cnt), 32'd0);
        step();
        reset = 1'b0; in_valid = 1'b0;

        // Streaming 0..15 with latency 1.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            @(negedge clock);
            if (i > 0) begin
                chk("stream_data", 32'(out_data), 32'(i - 1));
                chk("stream_par", 32'(out_parity), 32'(par_lit[i-1]));
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("stream_data", 32'(out_data), 32'd15);
        chk("stream_par15", 32'(out_parity), 32'd1);
        step();
        @(negedge clock);
        chk("stream_word_cnt", 32'(word_cnt), 32'd16);
        chk("stream_ovl", 32'(ovl_fires), 32'd0);

        // Backpressure fills the buffer; order must hold.
        step();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'd3; step();
        in_data = 4'd5; step();
        in_data = 4'd6;
        @(negedge clock);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", 32'(out_data), 32'd3);
        step();
        out_ready = 1'b1;
        @(negedge clock);
        chk("order_0", 32'(out_data), 32'd3);
        step();
        @(negedge clock);
        chk("order_1", 32'(out_data), 32'd5);
        chk("order_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        chk("order_2", 32'(out_data), 32'd6);
        step();

        // Simultaneous push and pop in ONE never stalls.
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; in_data = 4'($urandom);
            @(negedge clock);
            chk("pp_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        step();

        // Reset while FULL discards contents.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'd9; step();
        in_data = 4'd12; step();
        reset = 1'b1; step();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_wcnt", 32'(word_cnt), 32'd0);

        // Fault injection over 12 words.
        step();
        out_ready = 1'b1; inj_enable = 1'b1; ovl_fires = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_data = 4'($urandom);
            step();
        end
        in_valid = 1'b0; inj_enable = 1'b0;
        step(); step();
        @(negedge clock);
`ifdef IVL_UVM_ODD_PARITY_INJ_EN
        exp_inj = 3;
`else
        exp_inj = 0;
`endif
        chk("inj_cnt_final", 32'(inj_cnt), 32'(exp_inj));
        chk("inj_ovl_fires", 32'(ovl_fires), 32'(exp_inj));
        chk("inj_word_cnt", 32'(word_cnt), 32'd12);

        // Randomized traffic with occasional resets.
        step();
        for (int i = 0; i < 600; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = 4'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            inj_enable = 1'($urandom_range(0, 1));
            reset      = ($urandom_range(0, 79) == 0);
            step();
        end
        reset = 1'b0; in_valid = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
